mcs51_xdata_arb: RTL

Two-port arbiter and sequencer for the MCS-51 external data memory (XDATA). It shares one synchronous-read XDATA SRAM port between the CPU core's MOVX path and a DMA requester. It serialises their accesses through a small state machine, and an optional starvation guard keeps the DMA port from being locked out by back-to-back MOVX traffic. It sits between `mcs51_core`/DMA and the `xdata_mem` array inside `mcs51_mcu`.

---
 rtl/mcs51_xdata_arb_if.sv | 42 ++++
 rtl/mcs51_xdata_arb.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mcs51_xdata_arb_if.sv
// Bus bundle for mcs51_xdata_arb: CPU MOVX port, DMA port and the shared XDATA SRAM port.
// The slave modport is the arbiter's view; the master modport is the requesters/SRAM side.
interface mcs51_xdata_arb_if #(
    parameter int ADDR_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_ack;
    logic [7:0]        cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [7:0]        dma_wdata;
    logic              dma_ack;
    logic [7:0]        dma_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              grant_dma;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, grant_dma
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, grant_dma
    );
endinterface

// File: rtl/mcs51_xdata_arb.sv
// XDATA arbiter: CPU (fixed priority) and DMA share one synchronous-read SRAM via IDLE/ISSUE/DONE.
// Define MCS51_XDATA_ARB_STARVE_EN to enable the DMA starvation guard.
module mcs51_xdata_arb #(
    parameter int ADDR_W       = 16,
    parameter int STARVE_LIMIT = 8
) (
    input logic               clk,
    input logic               reset_n,
    mcs51_xdata_arb_if.slave  bus
);

    if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
        $error("STARVE_LIMIT must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              dma_own_q, dma_own_d;
    logic              rd_q, rd_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_ack_q, dma_ack_d;
    logic [7:0]        cpu_rdata_q, cpu_rdata_d;
    logic [7:0]        dma_rdata_q, dma_rdata_d;
    logic              dma_win;

`ifdef MCS51_XDATA_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_q, starve_d;
`endif

    always_comb begin
        state_d     = state_q;
        dma_own_d   = dma_own_q;
        rd_d        = rd_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
`ifdef MCS51_XDATA_ARB_STARVE_EN
        starve_d    = starve_q;
        dma_win     = bus.dma_req && (!bus.cpu_req || (starve_q == CNT_W'(STARVE_LIMIT)));
`else
        dma_win     = bus.dma_req && !bus.cpu_req;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.cpu_req || bus.dma_req) begin
                    state_d     = S_ISSUE;
                    dma_own_d   = dma_win;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dma_win ? bus.dma_we    : bus.cpu_we;
                    rd_d        = dma_win ? !bus.dma_we   : !bus.cpu_we;
                    mem_addr_d  = dma_win ? bus.dma_addr  : bus.cpu_addr;
                    mem_wdata_d = dma_win ? bus.dma_wdata : bus.cpu_wdata;
                end
`ifdef MCS51_XDATA_ARB_STARVE_EN
                if (!bus.dma_req || dma_win) begin
                    starve_d = '0;
                end else if (starve_q != CNT_W'(STARVE_LIMIT)) begin
                    starve_d = starve_q + 1'b1;
                end
`endif
            end
            S_ISSUE: begin
                state_d   = S_DONE;
                cpu_ack_d = !dma_own_q;
                dma_ack_d = dma_own_q;
            end
            S_DONE: begin
                state_d   = S_IDLE;
                dma_own_d = 1'b0;
                if (rd_q && dma_own_q) begin
                    dma_rdata_d = bus.mem_rdata;
                end else if (rd_q) begin
                    cpu_rdata_d = bus.mem_rdata;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            dma_own_q   <= 1'b0;
            rd_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
`ifdef MCS51_XDATA_ARB_STARVE_EN
            starve_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            dma_own_q   <= dma_own_d;
            rd_q        <= rd_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
`ifdef MCS51_XDATA_ARB_STARVE_EN
            starve_q    <= starve_d;
`endif
        end
    end

    // SRAM data only arrives in DONE, so the owner's rdata bypasses its holding register in that cycle.
    assign bus.cpu_rdata = (state_q == S_DONE && rd_q && !dma_own_q) ? bus.mem_rdata : cpu_rdata_q;
    assign bus.dma_rdata = (state_q == S_DONE && rd_q &&  dma_own_q) ? bus.mem_rdata : dma_rdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.dma_ack   = dma_ack_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.grant_dma = dma_own_q;

endmodule
